// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch sequencer: widths, opcode encodings, FSM state type.
`ifndef PROG_MEM_ADDR_WIDTH
`define PROG_MEM_ADDR_WIDTH 8
`endif

package fetch_ctrl_pkg;

  localparam int unsigned PROG_MEM_ADDR_W = `PROG_MEM_ADDR_WIDTH;
  localparam int unsigned INSTR_WIDTH     = 24;
  localparam int unsigned OPCODE_WIDTH    = 6;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_ADD  = 6'h01;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_BRA  = 6'h20;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_BEQ  = 6'h21;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_BNE  = 6'h22;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_HALT = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_branch_decode.sv
// Combinational opcode decode: branch-taken decision and HALT detection.
module branch_decode
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = OPCODE_WIDTH
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_z,
  output logic                taken,
  output logic                is_halt
);

  always_comb begin
    taken   = 1'b0;
    is_halt = 1'b0;
    // Unknown opcodes fall through as non-branch instructions.
    if (opcode == OPCODE_W'(OPCODE_BRA))       taken   = 1'b1;
    else if (opcode == OPCODE_W'(OPCODE_BEQ))  taken   = flag_z;
    else if (opcode == OPCODE_W'(OPCODE_BNE))  taken   = ~flag_z;
    else if (opcode == OPCODE_W'(OPCODE_HALT)) is_halt = 1'b1;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: reads program memory into IR and strobes the PC
// through a FETCH/DECODE/EXEC cycle.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = PROG_MEM_ADDR_W,
  parameter int unsigned INSTR_W  = INSTR_WIDTH,
  parameter int unsigned OPCODE_W = OPCODE_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               flag_z,
  input  logic               stall,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               pc_enable,
  output logic               pc_branch,
  output logic [ADDR_W-1:0]  pc_branch_addr,
  output logic               halted
);

  fetch_state_e       state, state_next;
  logic [INSTR_W-1:0] ir;
  logic               taken;
  logic               is_halt;

  branch_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_branch_decode (
    .opcode  (ir[INSTR_W-1 -: OPCODE_W]),
    .flag_z  (flag_z),
    .taken   (taken),
    .is_halt (is_halt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && mem_ready) ir <= mem_data;
    end
  end

  always_comb begin
    state_next  = state;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    instr_valid = 1'b0;
    pc_enable   = 1'b0;
    pc_branch   = 1'b0;
    halted      = 1'b0;
    case (state)
      ST_IDLE:   state_next = ST_FETCH;
      ST_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc_addr;
        if (mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        pc_enable  = ~is_halt;
        pc_branch  = taken;
        state_next = is_halt ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        if (!stall) state_next = ST_FETCH;
      end
      ST_HALT:   halted = 1'b1;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign instr          = ir;
  assign pc_branch_addr = ir[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (8-bit program address, 24-bit instructions).
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc_addr;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic        mem_ready;
  logic [23:0] mem_data;
  logic        flag_z;
  logic        stall;
  logic [23:0] instr;
  logic        instr_valid;
  logic        pc_enable;
  logic        pc_branch;
  logic [7:0]  pc_branch_addr;
  logic        halted;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Hand-encoded words: opcode in bits [23:18].
  localparam logic [23:0] I_ADD   = 24'h041234; // 0x01
  localparam logic [23:0] I_BRA   = 24'h80003C; // 0x20 -> 0x3C
  localparam logic [23:0] I_BEQ   = 24'h84003C; // 0x21 -> 0x3C
  localparam logic [23:0] I_BNE   = 24'h88003C; // 0x22 -> 0x3C
  localparam logic [23:0] I_BRAFF = 24'h8000FF; // 0x20 -> 0xFF
  localparam logic [23:0] I_UNK   = 24'h540012; // 0x15
  localparam logic [23:0] I_HALT  = 24'hFC0000; // 0x3F

  fetch_ctrl #(
    .ADDR_W   (8),
    .INSTR_W  (24),
    .OPCODE_W (6)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_addr        (pc_addr),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_data       (mem_data),
    .flag_z         (flag_z),
    .stall          (stall),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .pc_enable      (pc_enable),
    .pc_branch      (pc_branch),
    .pc_branch_addr (pc_branch_addr),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Entered one cycle before FETCH; leaves on the last EXEC cycle.
  task automatic do_instr(input logic [23:0] word, input logic [7:0] pc, input logic fz,
                          input int unsigned nstall, input logic exp_br);
    cyc();
    mem_data = word; mem_ready = 1'b1; pc_addr = pc; #1;
    check("fetch_rd", mem_rd, 1);
    check("fetch_addr", mem_addr, pc);
    check("fetch_en", pc_enable, 0);
    cyc();
    flag_z = fz; #1;
    check("dec_instr", instr, word);
    check("dec_en", pc_enable, 1);
    check("dec_br", pc_branch, exp_br);
    check("dec_tgt", pc_branch_addr, word[7:0]);
    check("dec_valid", instr_valid, 0);
    check("dec_rd", mem_rd, 0);
    cyc();
    stall = (nstall > 0); #1;
    check("exec_valid", instr_valid, 1);
    check("exec_en", pc_enable, 0);
    check("exec_rd", mem_rd, 0);
    for (int unsigned k = 1; k <= nstall; k++) begin
      cyc();
      stall = (k < nstall); #1;
      check("stall_valid", instr_valid, 1);
      check("stall_rd", mem_rd, 0);
      check("stall_en", pc_enable, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; pc_addr = '0; mem_ready = 1'b1; mem_data = I_ADD;
    flag_z = 1'b0; stall = 1'b0;
    #2;
    check("rst_rd", mem_rd, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_en", pc_enable, 0);
    check("rst_br", pc_branch, 0);
    check("rst_halt", halted, 0);
    cyc();
    reset = 1'b1; #1;
    check("idle_rd", mem_rd, 0);
    check("idle_en", pc_enable, 0);

    // Zero-wait ADD twice: 3-cycle cadence.
    do_instr(I_ADD, 8'h00, 1'b0, 0, 1'b0);
    do_instr(I_ADD, 8'h01, 1'b0, 0, 1'b0);

    // Two wait states.
    cyc();
    mem_ready = 1'b0; pc_addr = 8'h05; mem_data = 24'h0A5A5A; #1;
    check("ws1_rd", mem_rd, 1); check("ws1_addr", mem_addr, 8'h05);
    cyc(); #1;
    check("ws2_rd", mem_rd, 1); check("ws2_addr", mem_addr, 8'h05);
    check("ws2_instr", instr, I_ADD);
    cyc();
    mem_ready = 1'b1; #1;
    check("ws3_rd", mem_rd, 1); check("ws3_addr", mem_addr, 8'h05);
    cyc(); #1;
    check("ws_dec_instr", instr, 24'h0A5A5A);
    check("ws_dec_en", pc_enable, 1);
    check("ws_dec_br", pc_branch, 0);
    cyc(); #1;
    check("ws_exec_valid", instr_valid, 1);

    // Branch decisions.
    do_instr(I_BEQ,   8'h06, 1'b1, 0, 1'b1);
    do_instr(I_BEQ,   8'h3C, 1'b0, 0, 1'b0);
    do_instr(I_BNE,   8'h3D, 1'b1, 0, 1'b0);
    do_instr(I_BNE,   8'h3E, 1'b0, 0, 1'b1);
    do_instr(I_BRA,   8'h3C, 1'b0, 0, 1'b1);
    do_instr(I_BRA,   8'h3C, 1'b1, 0, 1'b1);
    do_instr(I_BRAFF, 8'h3C, 1'b0, 0, 1'b1);
    do_instr(I_UNK,   8'hFF, 1'b0, 0, 1'b0);
    do_instr(I_ADD,   8'h00, 1'b1, 0, 1'b0);

    // Stall for 4 cycles: 5 EXEC cycles total.
    do_instr(I_ADD, 8'h01, 1'b0, 4, 1'b0);
    do_instr(I_ADD, 8'h02, 1'b0, 0, 1'b0);

    // HALT.
    cyc();
    mem_data = I_HALT; mem_ready = 1'b1; pc_addr = 8'h03; #1;
    check("h_fetch_rd", mem_rd, 1);
    cyc(); #1;
    check("h_dec_instr", instr, I_HALT);
    check("h_dec_en", pc_enable, 0);
    check("h_dec_br", pc_branch, 0);
    check("h_dec_halt", halted, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      check("h_halted", halted, 1);
      check("h_rd", mem_rd, 0);
      check("h_en", pc_enable, 0);
      check("h_valid", instr_valid, 0);
    end
    reset = 1'b0; #1;
    check("h_rst_halt", halted, 0);
    check("h_rst_instr", instr, 0);
    cyc();
    reset = 1'b1; #1;
    check("h_idle_rd", mem_rd, 0);
    do_instr(I_ADD, 8'h00, 1'b0, 0, 1'b0);

    // Reset mid-FETCH with a late mem_ready.
    cyc();
    mem_ready = 1'b0; mem_data = 24'hABCDEF; pc_addr = 8'h01; #1;
    check("rf_rd", mem_rd, 1);
    check("rf_instr", instr, I_ADD);
    #1 reset = 1'b0; #1;
    check("rf_async_rd", mem_rd, 0);
    check("rf_async_instr", instr, 0);
    mem_ready = 1'b1;
    cyc(); #1;
    check("rf_hold_rd", mem_rd, 0);
    check("rf_hold_instr", instr, 0);
    cyc();
    reset = 1'b1; #1;
    check("rf_idle_rd", mem_rd, 0);
    check("rf_idle_instr", instr, 0);
    do_instr(I_BRA, 8'h01, 1'b0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
